// File: rtl/window_reader.sv
// Drains full rows from the row buffer, keeps a 3-row sliding window and
// streams 3x3 convolution windows (NUM_OF_WIN per beat) over valid/ready.
module window_reader #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DATA_OF_SET   = 128,
  parameter int unsigned KERNEL_SIZE   = 9,
  parameter int unsigned NUM_OF_WIN    = 1,
  parameter int unsigned ROW_CNT_WIDTH = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [ROW_CNT_WIDTH-1:0]                   num_rows,
  input  logic                                       row_valid,
  input  logic [DATA_OF_SET*DATA_WIDTH-1:0]          row_data,
  output logic                                       row_pop,
  output logic                                       win_valid,
  input  logic                                       win_ready,
  output logic [NUM_OF_WIN*KERNEL_SIZE*DATA_WIDTH-1:0] win_data,
  output logic [$clog2(DATA_OF_SET)-1:0]             win_col,
  output logic                                       win_last_in_row,
  output logic                                       win_last,
  output logic                                       busy,
  output logic                                       done
);

  localparam int unsigned COL_W    = $clog2(DATA_OF_SET);
  localparam int unsigned ROW_W    = DATA_OF_SET * DATA_WIDTH;
  localparam int unsigned LAST_COL = DATA_OF_SET - 2 - NUM_OF_WIN;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_EMIT, S_ADVANCE, S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [ROW_CNT_WIDTH-1:0] rows_in_q, rows_in_d;
  logic [ROW_CNT_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
  logic [2:0][ROW_W-1:0]    rows_c;
  logic                     shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rows_in_q  <= '0;
      num_rows_q <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      rows_in_q  <= rows_in_d;
      num_rows_q <= num_rows_d;
      col_q      <= col_d;
    end
  end

  // Row window registers carry only data, so they need no reset.
  always_ff @(posedge clk) begin
    r0_q <= r0_d;
    r1_q <= r1_d;
    r2_q <= r2_d;
  end

  always_comb begin
    state_d         = state_q;
    rows_in_d       = rows_in_q;
    num_rows_d      = num_rows_q;
    col_d           = col_q;
    row_pop         = 1'b0;
    win_valid       = 1'b0;
    win_last_in_row = 1'b0;
    win_last        = 1'b0;
    done            = 1'b0;
    busy            = (state_q != S_IDLE);
    shift           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_rows_d = num_rows;
          rows_in_d  = '0;
          col_d      = '0;
          state_d    = (num_rows < ROW_CNT_WIDTH'(3)) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        row_pop = row_valid;
        if (row_valid) begin
          shift     = 1'b1;
          rows_in_d = rows_in_q + ROW_CNT_WIDTH'(1);
          if (rows_in_q == ROW_CNT_WIDTH'(2)) begin
            state_d = S_EMIT;
            col_d   = '0;
          end
        end
      end
      S_EMIT: begin
        win_valid       = 1'b1;
        win_last_in_row = (col_q == COL_W'(LAST_COL));
        win_last        = win_last_in_row && (rows_in_q == num_rows_q);
        if (win_ready) begin
          if (win_last_in_row) begin
            state_d = win_last ? S_DONE : S_ADVANCE;
          end else begin
            col_d = col_q + COL_W'(NUM_OF_WIN);
          end
        end
      end
      S_ADVANCE: begin
        row_pop = row_valid;
        if (row_valid) begin
          shift     = 1'b1;
          rows_in_d = rows_in_q + ROW_CNT_WIDTH'(1);
          col_d     = '0;
          state_d   = S_EMIT;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A reset cycle must never consume a buffer row.
    if (rst) begin
      row_pop = 1'b0;
      shift   = 1'b0;
    end

    r0_d = shift ? r1_q     : r0_q;
    r1_d = shift ? r2_q     : r1_q;
    r2_d = shift ? row_data : r2_q;
  end

  assign rows_c  = {r2_q, r1_q, r0_q};
  assign win_col = col_q;

  // Window w element 3*ky+kx comes from row ky (oldest first), column col+w+kx.
  always_comb begin
    win_data = '0;
    for (int unsigned w = 0; w < NUM_OF_WIN; w++) begin
      for (int unsigned ky = 0; ky < 3; ky++) begin
        for (int unsigned kx = 0; kx < 3; kx++) begin
          win_data[(w*KERNEL_SIZE + 3*ky + kx)*DATA_WIDTH +: DATA_WIDTH] =
            rows_c[ky][(32'(col_q) + w + kx)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: doc/window_reader.md
Name: window_reader

Overview:
- Drain side of the row buffer. Pops full rows (DATA_OF_SET words) from the buffer's read port and keeps a 3-row sliding window.
- Emits 3x3 convolution windows (KERNEL_SIZE=9 words each) to the multiplier array, NUM_OF_WIN windows per beat, over a valid/ready handshake.
- Produces (DATA_OF_SET-2) valid-convolution columns per output row.
- Frame length is num_rows input rows, latched at start.

Parameters:
- DATA_WIDTH, 32, bits per pixel word
- DATA_OF_SET, 128, words per row; must be >= 3
- KERNEL_SIZE, 9, words per window; fixed 3x3
- NUM_OF_WIN, 1, windows per output beat; (DATA_OF_SET-2) % NUM_OF_WIN == 0 required
- ROW_CNT_WIDTH, 16, width of num_rows and internal row counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin frame; sampled only in IDLE
- num_rows  in  ROW_CNT_WIDTH  input rows in frame; latched on start
- row_valid  in  1  buffer has a row available (buffer not empty)
- row_data  in  DATA_OF_SET*DATA_WIDTH  buffer head row; word c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- row_pop  out  1  row consumed this cycle; buffer advances its read pointer
- win_valid  out  1  win_data valid
- win_ready  in  1  downstream accepts beat
- win_data  out  NUM_OF_WIN*KERNEL_SIZE*DATA_WIDTH  window w, element k = 3*ky+kx
- win_col  out  $clog2(DATA_OF_SET)  column of window 0 in the beat
- win_last_in_row  out  1  last beat of the current output row
- win_last  out  1  last beat of the frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state IDLE; row_pop, win_valid, win_last_in_row, win_last, busy, done = 0; row count and column = 0. Row registers are not required to clear.
- Reset is honoured in any state and mid-frame. No row_pop is issued in the reset cycle. Rows already popped are lost; the buffer is reset together with this block.
- States: IDLE, FILL, EMIT, ADVANCE, DONE.
- IDLE:
  - start=1 latches num_rows.
  - num_rows < 3: go to DONE, no pops.
  - Otherwise go to FILL with rows_in=0.
- FILL:
  - row_pop = row_valid, combinational, only in FILL/ADVANCE.
  - On a pop: r0<=r1, r1<=r2, r2<=row_data; rows_in++.
  - When rows_in reaches 3 on a pop: go to EMIT, col=0.
  - row_valid=0: wait, no pop.
- EMIT:
  - win_valid=1. win_data[w][3*ky+kx] = r_ky[col+w+kx]; ky=0 is the oldest row.
  - Outputs are held stable while win_ready=0.
  - On handshake, col += NUM_OF_WIN.
  - win_last_in_row = (col == DATA_OF_SET-2-NUM_OF_WIN).
  - win_last = win_last_in_row && rows_in == num_rows.
  - Handshake with win_last_in_row: go to DONE if win_last, else ADVANCE.
- ADVANCE:
  - win_valid=0. Pop one row as in FILL (shift, rows_in++), then go to EMIT with col=0.
  - Waits indefinitely on row_valid=0.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the IDLE cycle.
- start outside IDLE is ignored. num_rows changes after the latch are ignored.
- Beats per frame: (num_rows-2)*(DATA_OF_SET-2)/NUM_OF_WIN. Pops per frame: exactly num_rows.
- No pop ever occurs in EMIT, even with row_valid=1.
- Latency:
  - start to first pop: 1 cycle, if row_valid is high.
  - 3rd pop to first win_valid: 1 cycle.
  - Last-of-row handshake to next row's first win_valid: 2 cycles, if row_valid is high.
- No arithmetic on pixel data; words are passed bit-exact.

Test Plan (DATA_OF_SET=8, NUM_OF_WIN=2, pixel(r,c)=16*r+c):
- Basic frame: num_rows=4, row_valid always 1, win_ready always 1.
  - Expect 4 pops and 6 beats, win_col 0,2,4,0,2,4.
  - First beat window0 = {0,1,2,16,17,18,32,33,34}; window1 starts at 1.
  - win_last on beat 6; done pulse the cycle after.
- Backpressure: win_ready low for 5 cycles on beat 2.
  - win_data/win_col held constant; no pop; col advances only on handshake.
- Starved buffer: row_valid=0 for 10 cycles during FILL (after 2 pops) and during ADVANCE.
  - No row_pop, no win_valid, state holds; resumes with correct rows 2/3.
- Short frame: num_rows=2, then start again with num_rows=3.
  - First frame: done one cycle after start, zero pops, zero beats.
  - Second frame: 3 pops, 3 beats.
- Reset mid-EMIT during beat 2 of a num_rows=5 frame.
  - Next cycle: win_valid=0, busy=0, no pop.
  - Fresh start with num_rows=3 yields correct windows from the newly supplied rows.
- start pulsed while busy: ignored; total beats and pops unchanged.
